// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequencer that drives an external combinational 5-bit ALU (add/subtract
//   only) to execute ADD, SUB, CMP and MUL commands. MUL runs as repeated
//   addition, one ALU pass per cycle. One command is in flight at a time;
//   the result is held in registered response outputs until it is consumed.
//
// Parameters
//   MUL_EN    1: opcode 11 multiplies; 0: opcode 11 executes as ADD.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_op, cmd_a, cmd_b       opcode (00 ADD, 01 SUB, 10 CMP, 11 MUL), operands
//   alu_a, alu_b, alu_op       drive to the external ALU (op 0 add, 1 subtract)
//   alu_r, alu_cf/sf/zf        combinational ALU result and flags
//   rsp_valid/rsp_ready        response handshake
//   rsp_r, rsp_cf/sf/zf        registered result and flags
//   busy                       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_a,
  input  logic [4:0] cmd_b,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic       alu_op,
  input  logic [4:0] alu_r,
  input  logic       alu_cf,
  input  logic       alu_sf,
  input  logic       alu_zf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_r,
  output logic       rsp_cf,
  output logic       rsp_sf,
  output logic       rsp_zf,
  output logic       busy
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_reg, state_next;

  logic [1:0] op_reg;
  logic [4:0] a_reg;
  logic [4:0] b_reg;
  logic [4:0] acc_reg;
  logic [4:0] count_reg;
  logic       ovf_reg;
  logic [4:0] rsp_r_reg;
  logic       rsp_cf_reg;
  logic       rsp_sf_reg;
  logic       rsp_zf_reg;

  logic       handshake;
  logic       cmd_is_mul;
  logic       mul_skip;
  logic [4:0] mul_sum;
  logic       mul_ovf;

  // cmd_ready is gated by rst so nothing can be accepted while reset is held.
  assign cmd_ready  = (state_reg == S_IDLE) && !rst;
  assign handshake  = cmd_valid && cmd_ready;
  assign cmd_is_mul = MUL_EN && (cmd_op == OP_MUL);
  assign busy       = (state_reg != S_IDLE);
  assign rsp_valid  = (state_reg == S_DONE);

  assign rsp_r  = rsp_r_reg;
  assign rsp_cf = rsp_cf_reg;
  assign rsp_sf = rsp_sf_reg;
  assign rsp_zf = rsp_zf_reg;

  // A zero count on the MUL cycle means B was 0: no accumulation happens and
  // the (cleared) accumulator is returned as-is.
  assign mul_skip = (count_reg == 5'd0);
  assign mul_sum  = mul_skip ? acc_reg : alu_r;
  assign mul_ovf  = mul_skip ? ovf_reg : (ovf_reg | alu_cf);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and ALU drive
  always_comb begin
    state_next = state_reg;
    alu_a      = 5'd0;
    alu_b      = 5'd0;
    alu_op     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          state_next = cmd_is_mul ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a      = a_reg;
        alu_b      = b_reg;
        // Opcode 11 only reaches EXEC when multiplication is disabled; it adds.
        alu_op     = (op_reg == OP_SUB) || (op_reg == OP_CMP);
        state_next = S_DONE;
      end
      S_MUL: begin
        alu_a  = acc_reg;
        alu_b  = a_reg;
        alu_op = 1'b0;
        // Finish on the pass that takes count to zero, or immediately if B=0.
        if (count_reg <= 5'd1) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, multiply datapath and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= OP_ADD;
      a_reg      <= 5'd0;
      b_reg      <= 5'd0;
      acc_reg    <= 5'd0;
      count_reg  <= 5'd0;
      ovf_reg    <= 1'b0;
      rsp_r_reg  <= 5'd0;
      rsp_cf_reg <= 1'b0;
      rsp_sf_reg <= 1'b0;
      rsp_zf_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (handshake) begin
            op_reg    <= cmd_op;
            a_reg     <= cmd_a;
            b_reg     <= cmd_b;
            acc_reg   <= 5'd0;
            count_reg <= cmd_b;
            ovf_reg   <= 1'b0;
          end
        end
        S_EXEC: begin
          // CMP reports A unchanged but keeps the A-B flags.
          rsp_r_reg  <= (op_reg == OP_CMP) ? a_reg : alu_r;
          rsp_cf_reg <= alu_cf;
          rsp_sf_reg <= alu_sf;
          rsp_zf_reg <= alu_zf;
        end
        S_MUL: begin
          if (!mul_skip) begin
            acc_reg   <= alu_r;
            count_reg <= count_reg - 5'd1;
            ovf_reg   <= ovf_reg | alu_cf;
          end
          if (count_reg <= 5'd1) begin
            rsp_r_reg  <= mul_sum;
            rsp_cf_reg <= mul_ovf;
            rsp_sf_reg <= mul_sum[4];
            rsp_zf_reg <= (mul_sum == 5'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Bench for alu_seq_ctrl. Provides a behavioural 5-bit add/subtract ALU,
//   runs the directed scenarios followed by random commands, and compares
//   every response against results computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_a;
  logic [4:0] cmd_b;
  logic [4:0] alu_a;
  logic [4:0] alu_b;
  logic       alu_op;
  logic [4:0] alu_r;
  logic       alu_cf;
  logic       alu_sf;
  logic       alu_zf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_r;
  logic       rsp_cf;
  logic       rsp_sf;
  logic       rsp_zf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ALU: 6-bit arithmetic, carry out on add, borrow on subtract.
  logic [5:0] alu_wide;
  assign alu_wide = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_r    = alu_wide[4:0];
  assign alu_cf   = alu_wide[5];
  assign alu_sf   = alu_wide[4];
  assign alu_zf   = (alu_wide[4:0] == 5'd0);

  alu_seq_ctrl #(.MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .alu_cf    (alu_cf),
    .alu_sf    (alu_sf),
    .alu_zf    (alu_zf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_cf    (rsp_cf),
    .rsp_sf    (rsp_sf),
    .rsp_zf    (rsp_zf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, follow it to its response, then consume the response.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         input int rdy_wait, input bit hold_valid);
    int   ai, bi, prod, exp_lat, n;
    int   er;
    bit   ecf, esf, ezf;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'b00: begin er = (ai + bi) % 32; ecf = (ai + bi) > 31; exp_lat = 1; end
      2'b01: begin er = (ai - bi + 32) % 32; ecf = ai < bi; exp_lat = 1; end
      2'b10: begin er = ai; ecf = ai < bi; exp_lat = 1; end
      default: begin
        prod    = ai * bi;
        er      = prod % 32;
        ecf     = prod > 31;
        exp_lat = (bi > 1) ? bi : 1;
      end
    endcase
    // Flags for CMP come from A-B, not from the returned value.
    if (op == 2'b10) begin
      esf = (((ai - bi + 32) % 32) >= 16);
      ezf = (ai == bi);
    end else begin
      esf = (er >= 16);
      ezf = (er == 0);
    end

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    if (hold_valid) begin
      cmd_op = 2'b00;
      cmd_a  = ~a;
      cmd_b  = ~b;
    end else begin
      cmd_valid = 1'b0;
    end

    n = 0;
    while (!rsp_valid && n < 40) begin
      chk("busy_active", 32'(busy), 32'd1);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (op == 2'b11) begin
        chk("mul_alu_a", 32'(alu_a), 32'((ai * n) % 32));
        chk("mul_alu_b", 32'(alu_b), 32'(ai));
        chk("mul_alu_op", 32'(alu_op), 32'd0);
      end else begin
        chk("exec_alu_a", 32'(alu_a), 32'(ai));
        chk("exec_alu_b", 32'(alu_b), 32'(bi));
        chk("exec_alu_op", 32'(alu_op), (op == 2'b00) ? 32'd0 : 32'd1);
      end
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_r", 32'(rsp_r), 32'(er));
    chk("rsp_cf", 32'(rsp_cf), 32'(ecf));
    chk("rsp_sf", 32'(rsp_sf), 32'(esf));
    chk("rsp_zf", 32'(rsp_zf), 32'(ezf));
    chk("done_alu_drive", {27'd0, alu_a} | {27'd0, alu_b} | 32'(alu_op), 32'd0);

    for (int w = 0; w < rdy_wait; w++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_r", 32'(rsp_r), 32'(er));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rsp_r_held", 32'(rsp_r), 32'(er));
    $display("txn op=%0d a=%0d b=%0d -> r=%0d cf=%0d sf=%0d zf=%0d lat=%0d (exp r=%0d lat=%0d)",
             op, a, b, rsp_r, rsp_cf, rsp_sf, rsp_zf, n, er, exp_lat);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 5'd0;
    cmd_b     = 5'd0;
    rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp", {27'd0, rsp_r} | 32'(rsp_cf) | 32'(rsp_sf) | 32'(rsp_zf), 32'd0);
    chk("rst_alu", {27'd0, alu_a} | {27'd0, alu_b} | 32'(alu_op), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Directed scenarios
    run_cmd(2'b00, 5'b11100, 5'b11000, 0, 1'b0);  // ADD with carry
    run_cmd(2'b11, 5'b00011, 5'b00100, 1, 1'b0);  // MUL 3*4
    run_cmd(2'b11, 5'b00111, 5'b00101, 0, 1'b0);  // MUL 7*5 overflows
    run_cmd(2'b11, 5'b10101, 5'b00000, 0, 1'b0);  // MUL by zero
    run_cmd(2'b01, 5'b10100, 5'b00010, 3, 1'b1);  // SUB, backpressure, valid held
    run_cmd(2'b10, 5'b00101, 5'b01001, 0, 1'b0);  // CMP A<B
    run_cmd(2'b10, 5'b01001, 5'b01001, 0, 1'b0);  // CMP equal
    run_cmd(2'b11, 5'b11111, 5'b00001, 0, 1'b0);  // MUL by one

    // Reset pulsed during the second MUL cycle aborts with no response
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 5'b00111;
    cmd_b     = 5'b00101;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_r", 32'(rsp_r), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    chk("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
    run_cmd(2'b00, 5'b00001, 5'b00001, 0, 1'b0);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_EN, default 1, meaning MUL opcode is executed (0: MUL treated as ADD).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port cmd_valid  input  1  command present.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted this cycle if cmd_valid.
REQ-006 The block SHALL have port cmd_op  input  2  opcode: 00 ADD, 01 SUB, 10 CMP, 11 MUL.
REQ-007 The block SHALL have ports cmd_a, cmd_b  input  5 each  operands.
REQ-008 The block SHALL have ports alu_a, alu_b  output  5 each  ALU A/B drive.
REQ-009 The block SHALL have port alu_op  output  1  ALU OP drive, 0 add, 1 subtract.
REQ-010 The block SHALL have ports alu_r  input  5, alu_cf, alu_sf, alu_zf  input  1 each  combinational ALU result and flags.
REQ-011 The block SHALL have port rsp_valid  output  1  response present.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 The block SHALL have ports rsp_r  output  5, rsp_cf, rsp_sf, rsp_zf  output  1 each  registered result and flags.
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, MUL, DONE.
REQ-016 cmd_ready SHALL equal (state==IDLE); handshake = cmd_valid && cmd_ready at a rising edge, which latches cmd_op/cmd_a/cmd_b.
REQ-017 IDLE -> EXEC on handshake for ADD/SUB/CMP (and MUL when MUL_EN=0); IDLE -> MUL on handshake for MUL when MUL_EN=1.
REQ-018 In EXEC alu_a/alu_b SHALL be latched A/B, alu_op=0 for ADD, 1 for SUB/CMP; next edge captures alu_r and flags into rsp_* and moves to DONE.
REQ-019 CMP SHALL return rsp_r = latched A unchanged, flags from A-B as reported by the ALU.
REQ-020 MUL SHALL compute A*B by repeated addition: acc cleared and count loaded with B on acceptance; each MUL cycle drives alu_a=acc, alu_b=A, alu_op=0; on the edge acc<=alu_r, count<=count-1, ovf<=ovf|alu_cf.
REQ-021 MUL SHALL move to DONE on the edge where count reaches 0, with rsp_r=acc (mod 32), rsp_cf=sticky ovf, rsp_sf=rsp_r[4], rsp_zf=(rsp_r==0).
REQ-022 MUL with B=0 SHALL spend exactly one MUL cycle, perform no accumulation, and return rsp_r=0, cf=0, sf=0, zf=1.
REQ-023 Latency from accepting edge to rsp_valid high SHALL be 1 cycle for ADD/SUB/CMP and max(1,B) cycles for MUL.
REQ-024 In IDLE and DONE alu_a, alu_b, alu_op SHALL be driven 0.
REQ-025 rsp_valid SHALL be high only in DONE; rsp_* SHALL stay stable until rsp_ready; DONE -> IDLE on rsp_ready edge.
REQ-026 cmd_valid while busy SHALL be ignored (no latch, no state change); throughput is at most one command per 3 cycles.
REQ-027 rsp_* SHALL hold the last response value after returning to IDLE.

Reset
REQ-028 While rst is high, state SHALL be IDLE immediately (asynchronously); rsp_valid=0, busy=0, rsp_r=0, rsp_cf=rsp_sf=rsp_zf=0, alu_a=alu_b=0, alu_op=0, acc=0, count=0, ovf=0.
REQ-029 cmd_ready SHALL be 0 while rst is high, and 1 from the first clock after rst deasserts.
REQ-030 Reset asserted mid-EXEC/MUL/DONE SHALL abort the operation with no response produced.

Verification
REQ-031 ADD A=11100 B=11000 -> one cycle later rsp_valid=1, rsp_r=10100, cf=1, sf=1, zf=0; alu_op=0 during EXEC.
REQ-032 MUL A=00011 B=00100 -> rsp_valid after 4 cycles, rsp_r=01100, cf=0, sf=0, zf=0; alu_a sequence 0,3,6,9.
REQ-033 MUL A=00111 B=00101 -> rsp_valid after 5 cycles, rsp_r=00011, cf=1 (overflow on 5th add), zf=0.
REQ-034 MUL A=10101 B=00000 -> rsp_valid after 1 cycle, rsp_r=00000, cf=0, zf=1.
REQ-035 SUB A=10100 B=00010 with rsp_ready low 3 cycles and cmd_valid held high -> rsp_r=10010 stable, cmd_ready=0 throughout; IDLE one cycle after rsp_ready.
REQ-036 rst pulsed during cycle 2 of MUL A=00111 B=00101 -> busy=0, rsp_valid=0 immediately; next ADD A=00001 B=00001 returns 00010.
